fetch_pc_controller: RTL

Owns the architectural fetch PC and drives the instruction-memory request/response interface. Feeds each returned instruction to early_stage_immediate_decoder and uses its immediate to compute a statically predicted next PC: JAL taken, backward branch taken, everything else PC+4. Presents instruction, PC and prediction to the decode stage through a one-entry valid/ready output register. Accepts execute-stage redirects, which flush the fetch path.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/early_stage_immediate_decoder.sv | 35 +++
 rtl/fetch_pc_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        DROP
    } fetch_state_t;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/early_stage_immediate_decoder.sv
// Extracts the sign-extended immediate of an RV32 instruction from its opcode format.
module early_stage_immediate_decoder
    import fetch_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic [size-1:0] instr_i,
    output logic [size-1:0] imm_o
);

    logic signed [31:0] imm32;

    // Select the immediate layout by instruction format; unknown formats yield zero.
    always_comb begin
        imm32 = '0;
        case (instr_i[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            OPC_STORE:
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr_i[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm_o = size'(imm32);
    end

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch PC owner: issues one instruction-memory request at a time, statically
// predicts the next PC from the returned instruction and hands it to decode
// through a one-entry valid/ready register. Execute redirects flush the path.
module fetch_pc_controller
    import fetch_pkg::*;
#(
    parameter int unsigned     size     = 32,
    parameter logic [size-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [size-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [size-1:0] imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [size-1:0] if_instr_o,
    output logic [size-1:0] if_pc_o,
    output logic            if_pred_taken_o,
    output logic [size-1:0] if_pred_target_o,
    input  logic            redirect_i,
    input  logic [size-1:0] redirect_pc_i
);

    fetch_state_t    state_q;
    logic [size-1:0] pc_q;
    logic            valid_q;
    logic [size-1:0] instr_q;
    logic [size-1:0] out_pc_q;
    logic            taken_q;
    logic [size-1:0] target_q;

    logic [size-1:0] imm_w;
    logic [6:0]      opcode_w;
    logic            consume_w;
    logic            granted_w;
    logic            pred_taken_d;
    logic [size-1:0] pred_target_d;

    early_stage_immediate_decoder #(
        .size(size)
    ) u_imm_dec (
        .instr_i(imem_rdata_i),
        .imm_o  (imm_w)
    );

    assign opcode_w    = imem_rdata_i[6:0];
    assign consume_w   = valid_q & if_ready_i;
    // Request only when the output slot will have room for the response.
    assign imem_req_o  = (state_q == FETCH) & (~valid_q | if_ready_i);
    assign granted_w   = imem_req_o & imem_gnt_i;
    assign imem_addr_o = pc_q;

    assign if_valid_o       = valid_q;
    assign if_instr_o       = instr_q;
    assign if_pc_o          = out_pc_q;
    assign if_pred_taken_o  = taken_q;
    assign if_pred_target_o = target_q;

    // Static prediction: JAL and backward branches taken, everything else falls through.
    always_comb begin
        pred_taken_d  = (opcode_w == OPC_JAL) |
                        ((opcode_w == OPC_BRANCH) & imm_w[size-1]);
        pred_target_d = pred_taken_d ? (pc_q + imm_w) : (pc_q + size'(4));
    end

    // Fetch FSM, PC register and decode-facing output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= size'(NOP_INSTR);
            out_pc_q <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            valid_q <= 1'b0;
            case (state_q)
                IDLE:    state_q <= FETCH;
                FETCH:   state_q <= granted_w ? DROP : FETCH;
                WAIT:    state_q <= imem_rvalid_i ? FETCH : DROP;
                // The outstanding response still has to be swallowed; a redirect
                // here only retargets the PC and does not restart the drain.
                DROP:    state_q <= imem_rvalid_i ? FETCH : DROP;
                default: state_q <= IDLE;
            endcase
        end else begin
            if (consume_w) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (granted_w) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        valid_q  <= 1'b1;
                        instr_q  <= imem_rdata_i;
                        out_pc_q <= pc_q;
                        taken_q  <= pred_taken_d;
                        target_q <= pred_target_d;
                        pc_q     <= pred_target_d;
                        state_q  <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid_i) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
